// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcodes, FSM states, requester count.
package alu_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_EQ  = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when the caller reports a transfer.
module rr_arb2 (
  input  logic       clk,
  input  logic       arst,
  input  logic [1:0] request,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins first contention.
  logic last;

  always_comb begin
    grant = 2'b00;
    case (request)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst)        last <= 1'b1;
    else if (advance) last <= grant[1];
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one external registered ALU between two requesters; one operation in flight at a time.
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_select,
  output logic                     alu_enable,
  input  logic [2*WIDTH-1:0]       alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic                     rsp_err,
  output logic [15:0]              op_count
);

  sched_state_t     state;
  logic [1:0]       grant;
  logic             accept;
  logic             sel_id;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;
  logic             sel_div0;
  logic             id_q;
  logic [WIDTH-1:0] a_q, b_q;
  alu_op_t          op_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .arst    (arst),
    .request (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is only offered from IDLE and is forced low while reset is held.
  assign req_ready = (state == IDLE && arst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign sel_id   = grant[1];
  assign sel_a    = sel_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b    = sel_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign sel_op   = sel_id ? req_op[5:3] : req_op[2:0];
  assign sel_div0 = (sel_op == OP_DIV) && (sel_b == '0);

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_select = op_q;
  assign rsp_id     = id_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state      <= IDLE;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      alu_enable <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          id_q <= sel_id;
          a_q  <= sel_a;
          b_q  <= sel_b;
          op_q <= alu_op_t'(sel_op);
          // Divide-by-zero never touches the ALU; answer straight away.
          if (sel_div0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
          end else begin
            state      <= ISSUE;
            alu_enable <= 1'b1;
          end
        end
        ISSUE: begin
          alu_enable <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          rsp_data  <= alu_out;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: external ALU model, directed scenarios, randomized transactions, counter wrap.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           arst;
  logic [1:0]     req_valid, req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [5:0]     req_op;
  logic [W-1:0]   alu_a, alu_b;
  logic [2:0]     alu_select;
  logic           alu_enable;
  logic [2*W-1:0] alu_out = '0;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [2*W-1:0] rsp_data;
  logic [15:0]    op_count;

  int checks = 0;
  int errors = 0;
  int done = 0;      // completions since last reset
  int last_gnt = 1;  // requester that won most recently

  always #5 clk = ~clk;

  alu_sched #(.WIDTH(W)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_enable(alu_enable),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
  );

  function automatic logic [2*W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
    int unsigned x, y, r;
    x = a; y = b; r = 0;
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (x == y) ? 1 : 0;
      3'd6: r = x * y;
      default: r = (y == 0) ? 0 : x / y;
    endcase
    return r[2*W-1:0];
  endfunction

  // External ALU: result registered on the edge that ends the enable cycle.
  always @(posedge clk) if (alu_enable) alu_out <= alu_ref(alu_a, alu_b, alu_select);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_sel"}, alu_select, 0);
    chk({tag, "_alu_en"}, alu_enable, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_op_count"}, op_count, 0);
  endtask

  // One transaction from the IDLE negedge through the response handshake.
  task automatic txn(input logic [1:0] vm, input logic [2:0] o0, input logic [2:0] o1,
                     input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input int stall, input bit keep);
    int win, lat, ens, seen;
    logic [W-1:0] ea, eb;
    logic [2:0] eo;
    logic [2*W-1:0] ed;
    bit dz;
    req_valid = vm; req_op = {o1, o0}; req_a = {a1, a0}; req_b = {b1, b0}; rsp_ready = 1'b0;
    win = (vm == 2'b11) ? ((last_gnt == 1) ? 0 : 1) : ((vm == 2'b10) ? 1 : 0);
    last_gnt = win;
    ea = win ? a1 : a0; eb = win ? b1 : b0; eo = win ? o1 : o0;
    dz = (eo == 3'b111) && (eb == 0);
    ed = dz ? '0 : alu_ref(ea, eb, eo);
    lat = dz ? 1 : 3;
    #1;
    chk("grant", req_ready, 32'(2'b01 << win));
    seen = 0; ens = 0;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      @(negedge clk);
      ens += int'(alu_enable);
      chk("ready_busy", req_ready, 0);
      if (c == 1 && !dz) begin
        chk("alu_en", alu_enable, 1);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_sel", alu_select, eo);
      end
      if (rsp_valid) seen = c;
      if (c == 1 && !keep) req_valid = 2'b00;
    end
    chk("latency", seen, lat);
    chk("alu_en_count", ens, dz ? 0 : 1);
    chk("rsp_id", rsp_id, win);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", rsp_err, dz);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_id", rsp_id, win);
      chk("hold_ready", req_ready, 0);
      chk("hold_count", op_count, done & 16'hFFFF);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    done++;
    chk("rsp_done", rsp_valid, 0);
    chk("op_count", op_count, done & 16'hFFFF);
  endtask

  initial begin
    int guard;
    arst = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    req_valid = 2'b00;
    arst = 1'b1;
    @(negedge clk);

    // Single add, then divide-by-zero on requester 1, then sustained contention.
    txn(2'b01, 3'd0, 3'd0, 4'd9, 4'd8, 4'd0, 4'd0, 0, 1'b0);
    txn(2'b10, 3'd0, 3'd7, 4'd0, 4'd0, 4'd7, 4'd0, 0, 1'b0);
    for (int i = 0; i < 4; i++) txn(2'b11, 3'd0, 3'd6, 4'd1, 4'd1, 4'd3, 4'd5, 0, 1'b1);
    req_valid = 2'b00;

    // Long back-pressure, then rsp_ready while idle does nothing.
    txn(2'b10, 3'd4, 3'd1, 4'd0, 4'd0, 4'd2, 4'd5, 5, 1'b0);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_rsp_ready_valid", rsp_valid, 0);
    chk("idle_rsp_ready_count", op_count, done & 16'hFFFF);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] rb0, rb1;
      rb0 = ($urandom_range(0, 3) == 0) ? 4'd0 : W'($urandom);
      rb1 = ($urandom_range(0, 3) == 0) ? 4'd0 : W'($urandom);
      txn(2'($urandom_range(1, 3)), 3'($urandom), 3'($urandom), W'($urandom), rb0,
          W'($urandom), rb1, $urandom_range(0, 2), 1'b0);
    end

    // Reset while the ALU result is being captured.
    req_valid = 2'b01; req_op = 6'd0; req_a = {4'd0, 4'd3}; req_b = {4'd0, 4'd4};
    repeat (2) @(negedge clk);
    arst = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    req_valid = 2'b00;
    @(negedge clk);
    arst = 1'b1; last_gnt = 1; done = 0;
    repeat (2) @(negedge clk);
    chk("no_stale_valid", rsp_valid, 0);
    chk("no_stale_count", op_count, 0);
    txn(2'b10, 3'd0, 3'd2, 4'd0, 4'd0, 4'd6, 4'd3, 0, 1'b0);
    txn(2'b11, 3'd1, 3'd5, 4'd4, 4'd9, 4'd5, 4'd5, 1, 1'b0);

    // Back-to-back divide-by-zero completions until the counter wraps.
    req_valid = 2'b01; req_op = {3'd0, 3'd7}; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    guard = 0;
    while (done < 65536 && guard < 140000) begin
      @(negedge clk);
      guard++;
      if (rsp_valid && rsp_ready) begin
        done++;
        if (done == 65536) begin
          req_valid = 2'b00;
          chk("pre_wrap_count", op_count, 16'hFFFF);
        end
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("wrap_done", done, 65536);
    chk("wrap_count", op_count, 0);
    chk("wrap_idle", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter WIDTH, default 4, operand width of the shared ALU.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 arst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-006 req_a, req_b  input  2*WIDTH each  operands; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 req_op  input  6  3-bit opcode per requester (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 eq, 110 mul, 111 div).
REQ-008 alu_a, alu_b  output  WIDTH each  operands driven to the ALU.
REQ-009 alu_select  output  3  opcode driven to the ALU.
REQ-010 alu_enable  output  1  ALU capture enable.
REQ-011 alu_out  input  2*WIDTH  registered ALU result, valid one cycle after alu_enable.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_data  output  2*WIDTH  result.
REQ-016 rsp_err  output  1  divide-by-zero flag.
REQ-017 op_count  output  16  count of completed responses.

Function
REQ-018 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-019 IDLE: req_ready is one-hot on the round-robin grant winner among asserted req_valid bits, and zero when no request is valid.
REQ-020 Round-robin: if both requesters are valid, grant the one not granted last; a single valid requester always wins.
REQ-021 On accept, latch id, a, b and op, then go to ISSUE.
REQ-022 Divide-by-zero (op 111 with b == 0): skip the ALU and go directly to RESP with rsp_data = 0 and rsp_err = 1.
REQ-023 ISSUE: alu_enable = 1 for exactly one cycle with the latched operands and opcode, then go to CAPTURE.
REQ-024 CAPTURE: register alu_out into rsp_data with rsp_err = 0, then go to RESP.
REQ-025 RESP: hold rsp_valid high; rsp_id, rsp_data and rsp_err stay stable until rsp_ready is high.
REQ-026 When rsp_valid and rsp_ready are both high, return to IDLE and increment op_count, wrapping from 0xFFFF to 0.
REQ-027 req_ready is low in all states except IDLE; there is no acceptance while a response is pending.
REQ-028 Latency for an accept at edge T: alu_enable high in cycle T+1, rsp_valid high from T+3; the divide-by-zero path has rsp_valid high from T+1.
REQ-029 alu_a, alu_b and alu_select hold the latched values outside ISSUE; alu_enable is 0 outside ISSUE.
REQ-030 rsp_ready while rsp_valid is low has no effect.
REQ-031 The round-robin pointer updates only on an accepted transfer.

Reset
REQ-032 When arst is low, the FSM is in IDLE and all outputs are 0: req_ready, alu_*, rsp_valid, rsp_id, rsp_data, rsp_err and op_count.
REQ-033 Reset asserted in any state aborts the in-flight operation with no response produced.
REQ-034 After reset, the round-robin pointer favours requester 0 on the first contention.

Structure
REQ-035 Shared package alu_pkg holds the opcode constants/enum (OP_ADD to OP_DIV) and the state enum sched_state_t.
REQ-036 The round-robin arbiter is a separate sub-module rr_arb2 (inputs: request[1:0], advance; output: one-hot grant; contains the pointer register).
REQ-037 The ALU is instantiated outside alu_sched; alu_sched connects only through its alu_* ports.

Verification
REQ-038 After reset, req0 add a=9, b=8 -> alu_enable in cycle T+1; rsp_valid at T+3 with rsp_id=0, rsp_data=0x11, rsp_err=0, op_count=1.
REQ-039 req0 and req1 both valid continuously (add 1+1, mul 3*5) -> grants alternate 0,1,0,1; responses 0x02, 0x0F, 0x02, 0x0F.
REQ-040 req1 div a=7, b=0 -> rsp_valid at T+1 with rsp_err=1, rsp_data=0, and alu_enable never asserted.
REQ-041 rsp_ready held low for 5 cycles during RESP -> rsp_data/rsp_id stable, req_ready=0 throughout, op_count unchanged until the handshake.
REQ-042 arst driven low during CAPTURE -> all outputs 0 immediately; after release, a new req1 request is served and no stale response appears.
REQ-043 op_count preloaded near wrap via 65536 completions -> op_count reads 0 after the 65536th response.
